// File: rtl/veritune_rec_play.sv
// Veritune record/stop/play controller with an internal sample buffer.
// Samples are captured at the strobed rate while recording and replayed
// through a fixed-point phase accumulator, so Freq changes pitch and speed.
module veritune_rec_play #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 12,
   parameter int STEP_FRAC = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Rec,
   input  logic              Stop,
   input  logic              Play,
   input  logic              Loop,
   input  logic              Sample_Tick,
   input  logic [7:0]        Freq,
   input  logic [DATA_W-1:0] Audio_In,
   output logic [DATA_W-1:0] Audio_Out,
   output logic              Out_Valid,
   output logic [ADDR_W:0]   Rec_Len,
   output logic              Full,
   output logic              q_I,
   output logic              q_Rec,
   output logic              q_Stop,
   output logic              q_Play
);

   localparam int DEPTH   = 1 << ADDR_W;
   localparam int PHASE_W = ADDR_W + 1 + STEP_FRAC;
   localparam int SUM_W   = PHASE_W + 8;

   localparam logic [ADDR_W:0]   LAST_LEN = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0]   LEN_ONE  = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

   typedef enum logic [3:0] {
      S_I    = 4'b0001,
      S_REC  = 4'b0010,
      S_STOP = 4'b0100,
      S_PLAY = 4'b1000
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   wptr;
   logic [PHASE_W-1:0]  phase;
   logic [DATA_W-1:0]   mem [0:DEPTH-1];

   logic [SUM_W-1:0]    step_w;
   logic [SUM_W-1:0]    len_fx;
   logic [SUM_W-1:0]    phase_next;
   logic [SUM_W-1:0]    wrap1;
   logic [SUM_W-1:0]    wrap2;
   logic [PHASE_W-1:0]  phase_wrap;
   logic                at_end;
   logic [ADDR_W-1:0]   rd_addr;

   assign {q_Play, q_Stop, q_Rec, q_I} = state;
   assign rd_addr = phase[STEP_FRAC +: ADDR_W];

   // Next phase, end-of-recording detection and loop wrap (Freq 0 means unity)
   always_comb begin
      step_w = '0;
      if (Freq == 8'd0) begin
         step_w[STEP_FRAC] = 1'b1;
      end else begin
         step_w[7:0] = Freq;
      end
      len_fx     = SUM_W'(Rec_Len) << STEP_FRAC;
      phase_next = SUM_W'(phase) + step_w;
      at_end     = (phase_next >= len_fx);
      wrap1      = phase_next - len_fx;
      wrap2      = wrap1 - len_fx;
      phase_wrap = '0;
      if (wrap1 < len_fx) begin
         phase_wrap = PHASE_W'(wrap1);
      end else if (wrap2 < len_fx) begin
         phase_wrap = PHASE_W'(wrap2);
      end
   end

   // Sample buffer write port; contents survive reset on purpose
   always_ff @(posedge Clk) begin
      if (!Reset && state == S_REC && Sample_Tick) begin
         mem[wptr] <= Audio_In;
      end
   end

   // Control FSM with registered playback output and recording bookkeeping
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_I;
         wptr      <= '0;
         phase     <= '0;
         Rec_Len   <= '0;
         Full      <= 1'b0;
         Audio_Out <= '0;
         Out_Valid <= 1'b0;
      end else begin
         Out_Valid <= 1'b0;
         case (state)
            S_I: begin
               if (Rec) begin
                  state   <= S_REC;
                  wptr    <= '0;
                  Rec_Len <= '0;
                  Full    <= 1'b0;
               end
            end
            S_REC: begin
               if (Sample_Tick) begin
                  wptr    <= wptr + PTR_ONE;
                  Rec_Len <= Rec_Len + LEN_ONE;
                  if (Rec_Len == LAST_LEN) begin
                     Full  <= 1'b1;
                     state <= S_STOP;
                  end
               end
               if (Stop) begin
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (Rec) begin
                  state   <= S_REC;
                  wptr    <= '0;
                  Rec_Len <= '0;
                  Full    <= 1'b0;
               end else if (Play && Rec_Len != '0) begin
                  state <= S_PLAY;
                  phase <= '0;
               end
            end
            S_PLAY: begin
               if (Sample_Tick) begin
                  Audio_Out <= mem[rd_addr];
                  Out_Valid <= 1'b1;
                  if (at_end) begin
                     if (Loop) begin
                        phase <= phase_wrap;
                     end else begin
                        state <= S_STOP;
                     end
                  end else begin
                     phase <= PHASE_W'(phase_next);
                  end
               end
               if (Stop) begin
                  state <= S_STOP;
               end
            end
            default: begin
               state <= S_I;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_veritune_rec_play.sv
// Self-checking bench for veritune_rec_play with an 8-entry buffer.
// A behavioural model predicts every playback sample into a scoreboard queue
// that an independent monitor drains whenever Out_Valid is seen.
module tb_veritune_rec_play;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 3;
   localparam int STEP_FRAC = 4;
   localparam int DEPTH     = 1 << ADDR_W;
   localparam int UNITY     = 1 << STEP_FRAC;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              Rec = 1'b0;
   logic              Stop = 1'b0;
   logic              Play = 1'b0;
   logic              Loop = 1'b0;
   logic              Sample_Tick = 1'b0;
   logic [7:0]        Freq = 8'd16;
   logic [DATA_W-1:0] Audio_In = '0;
   logic [DATA_W-1:0] Audio_Out;
   logic              Out_Valid;
   logic [ADDR_W:0]   Rec_Len;
   logic              Full;
   logic              q_I;
   logic              q_Rec;
   logic              q_Stop;
   logic              q_Play;

   veritune_rec_play #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .STEP_FRAC(STEP_FRAC)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Rec(Rec),
      .Stop(Stop),
      .Play(Play),
      .Loop(Loop),
      .Sample_Tick(Sample_Tick),
      .Freq(Freq),
      .Audio_In(Audio_In),
      .Audio_Out(Audio_Out),
      .Out_Valid(Out_Valid),
      .Rec_Len(Rec_Len),
      .Full(Full),
      .q_I(q_I),
      .q_Rec(q_Rec),
      .q_Stop(q_Stop),
      .q_Play(q_Play)
   );

   // Free-running 10-unit clock
   always #5 Clk = ~Clk;

   typedef enum int {M_IDLE, M_REC, M_STOP, M_PLAY} mode_t;

   mode_t m_mode = M_IDLE;
   int    m_mem [DEPTH];
   int    m_len = 0;
   bit    m_full = 1'b0;
   int    m_phase = 0;
   int    m_out = 0;
   bit    m_valid = 1'b0;

   int expQ[$];
   int gotQ[$];
   int refSeq[$];
   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every Out_Valid pulse consumes one predicted sample
   always @(negedge Clk) begin
      if (Out_Valid === 1'b1) begin
         gotQ.push_back(int'(Audio_Out));
         if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_valid: got Out_Valid with Audio_Out %0d, expected no output at t=%0t", Audio_Out, $time);
         end else begin
            checkOutput("scoreboard_audio_out", 32'(Audio_Out), 32'(expQ.pop_front()));
         end
      end
   end

   // Reference model: what the controller should do at the coming edge
   function automatic void modelEdge();
      int stepv;
      int pn;
      m_valid = 1'b0;
      if (Reset) begin
         m_mode  = M_IDLE;
         m_len   = 0;
         m_full  = 1'b0;
         m_phase = 0;
         m_out   = 0;
         return;
      end
      case (m_mode)
         M_IDLE: begin
            if (Rec) begin
               m_mode = M_REC;
               m_len  = 0;
               m_full = 1'b0;
            end
         end
         M_REC: begin
            if (Sample_Tick) begin
               m_mem[m_len] = int'(Audio_In);
               m_len++;
               if (m_len == DEPTH) begin
                  m_full = 1'b1;
                  m_mode = M_STOP;
               end
            end
            if (Stop) m_mode = M_STOP;
         end
         M_STOP: begin
            if (Rec) begin
               m_mode = M_REC;
               m_len  = 0;
               m_full = 1'b0;
            end else if (Play && m_len != 0) begin
               m_mode  = M_PLAY;
               m_phase = 0;
            end
         end
         default: begin
            if (Sample_Tick) begin
               m_out   = m_mem[m_phase / UNITY];
               m_valid = 1'b1;
               expQ.push_back(m_out);
               stepv = (Freq == 8'd0) ? UNITY : int'(Freq);
               pn = m_phase + stepv;
               if (pn / UNITY >= m_len) begin
                  if (Loop) begin
                     pn = pn - m_len * UNITY;
                     if (pn >= m_len * UNITY) pn = pn - m_len * UNITY;
                     if (pn >= m_len * UNITY) pn = 0;
                     m_phase = pn;
                  end else begin
                     m_mode = M_STOP;
                  end
               end else begin
                  m_phase = pn;
               end
            end
            if (Stop) m_mode = M_STOP;
         end
      endcase
   endfunction

   function automatic logic [3:0] modeFlags(input mode_t m);
      case (m)
         M_IDLE:  return 4'b0001;
         M_REC:   return 4'b0010;
         M_STOP:  return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

   // One clock of stimulus: drive, predict, clock, then compare visible state
   task automatic applyStimulus(input bit rst, input bit rec, input bit stop, input bit play,
                                input bit tick, input logic [DATA_W-1:0] din);
      Reset = rst;
      Rec = rec;
      Stop = stop;
      Play = play;
      Sample_Tick = tick;
      Audio_In = din;
      modelEdge();
      @(posedge Clk);
      #1;
      checkOutput("state_flags", 32'({q_Play, q_Stop, q_Rec, q_I}), 32'(modeFlags(m_mode)));
      checkOutput("rec_len", 32'(Rec_Len), 32'(m_len));
      checkOutput("full", 32'(Full), 32'(m_full));
      checkOutput("audio_out", 32'(Audio_Out), 32'(m_out));
      checkOutput("out_valid", 32'(Out_Valid), 32'(m_valid));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, '0);
   endtask

   task automatic recordSample(input logic [DATA_W-1:0] din, input int gap);
      applyStimulus(0, 0, 0, 0, 1, din);
      idle(gap - 1);
   endtask

   // Start from STOP, play with the given settings for nTicks ticks every gap cycles
   task automatic playRun(input bit loop, input logic [7:0] freq, input int nTicks, input int gap);
      Loop = loop;
      Freq = freq;
      gotQ.delete();
      applyStimulus(0, 0, 0, 1, 0, '0);
      for (int i = 0; i < nTicks; i++) begin
         applyStimulus(0, 0, 0, 0, 1, '0);
         idle(gap - 1);
      end
      idle(2);
   endtask

   task automatic checkSeq(input string name);
      checkOutput({name, "_count"}, 32'(gotQ.size()), 32'(refSeq.size()));
      for (int i = 0; i < refSeq.size() && i < gotQ.size(); i++) begin
         checkOutput({name, "_sample"}, 32'(gotQ[i]), 32'(refSeq[i]));
      end
   endtask

   task automatic checkDrained(input string name);
      checkOutput(name, 32'(expQ.size()), 32'(0));
   endtask

   initial begin
      int len;
      int gap;
      bit loopSel;
      logic [7:0] f;

      applyStimulus(1, 0, 0, 0, 0, '0);
      applyStimulus(1, 0, 0, 0, 0, '0);
      checkOutput("reset_q_I", 32'(q_I), 32'(1));

      // Test 1: record five samples then stop
      applyStimulus(0, 1, 0, 0, 0, '0);
      for (int i = 1; i <= 5; i++) recordSample(DATA_W'(i * 10), 2);
      applyStimulus(0, 0, 1, 0, 0, '0);
      checkOutput("t1_q_stop", 32'(q_Stop), 32'(1));
      checkOutput("t1_rec_len", 32'(Rec_Len), 32'(5));
      checkOutput("t1_full", 32'(Full), 32'(0));

      // Test 2 and 3: speeds 1, 2, 0.5 and Freq 0 as unity
      playRun(0, 8'd16, 7, 4);
      refSeq = {10, 20, 30, 40, 50};
      checkSeq("t2_unity");
      checkOutput("t2_q_stop", 32'(q_Stop), 32'(1));
      playRun(0, 8'd32, 5, 4);
      refSeq = {10, 30, 50};
      checkSeq("t3_double");
      playRun(0, 8'd8, 12, 3);
      refSeq = {10, 10, 20, 20, 30, 30, 40, 40, 50, 50};
      checkSeq("t3_half");
      playRun(0, 8'd0, 7, 2);
      refSeq = {10, 20, 30, 40, 50};
      checkSeq("t3_freq0");
      checkDrained("t3_pending");

      // Test 4: looping at 1.5x, then stop holds the last sample
      playRun(1, 8'd24, 5, 4);
      applyStimulus(0, 0, 1, 0, 0, '0);
      idle(2);
      refSeq = {10, 20, 40, 50, 20};
      checkSeq("t4_loop");
      checkOutput("t4_q_stop", 32'(q_Stop), 32'(1));
      checkOutput("t4_hold", 32'(Audio_Out), 32'(20));

      // Test 5: overfill the buffer, the ninth sample is dropped
      applyStimulus(0, 1, 0, 0, 0, '0);
      for (int i = 1; i <= 9; i++) recordSample(DATA_W'(i), 2);
      checkOutput("t5_full", 32'(Full), 32'(1));
      checkOutput("t5_rec_len", 32'(Rec_Len), 32'(8));
      checkOutput("t5_q_stop", 32'(q_Stop), 32'(1));
      playRun(0, 8'd16, 9, 2);
      refSeq = {1, 2, 3, 4, 5, 6, 7, 8};
      checkSeq("t5_contents");
      applyStimulus(0, 1, 0, 1, 0, '0);
      checkOutput("t5_rec_wins", 32'(q_Rec), 32'(1));
      checkOutput("t5_len_cleared", 32'(Rec_Len), 32'(0));
      checkOutput("t5_full_cleared", 32'(Full), 32'(0));
      for (int i = 0; i < 4; i++) recordSample(DATA_W'(100 + i), 1);
      applyStimulus(0, 0, 1, 0, 0, '0);

      // Test 6: reset during playback, then Play is ignored in I
      Loop = 1'b1;
      Freq = 8'd16;
      applyStimulus(0, 0, 0, 1, 0, '0);
      applyStimulus(0, 0, 0, 0, 1, '0);
      applyStimulus(0, 0, 0, 0, 1, '0);
      applyStimulus(1, 0, 0, 0, 1, '0);
      checkOutput("t6_q_I", 32'(q_I), 32'(1));
      checkOutput("t6_audio_out", 32'(Audio_Out), 32'(0));
      checkOutput("t6_out_valid", 32'(Out_Valid), 32'(0));
      checkOutput("t6_rec_len", 32'(Rec_Len), 32'(0));
      applyStimulus(0, 0, 0, 1, 0, '0);
      applyStimulus(0, 0, 1, 1, 1, '0);
      checkOutput("t6_play_in_idle", 32'(q_I), 32'(1));
      idle(2);
      checkDrained("t6_pending");

      // Randomised recordings and playbacks against the model
      for (int iter = 0; iter < 20; iter++) begin
         len = int'($urandom_range(4, 8));
         gap = int'($urandom_range(1, 3));
         applyStimulus(0, 1, 0, 0, 0, '0);
         for (int i = 0; i < len; i++) recordSample(DATA_W'($urandom), gap);
         applyStimulus(0, 0, 1, 0, 0, '0);
         loopSel = 1'($urandom_range(0, 1));
         f = loopSel ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 255));
         Loop = loopSel;
         Freq = f;
         applyStimulus(0, 0, 0, 1, 0, '0);
         for (int c = 0; c < 30; c++) begin
            if (m_mode == M_PLAY) begin
               applyStimulus(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
                             ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), DATA_W'($urandom));
            end else begin
               applyStimulus(0, 0, 0, 0, 1'($urandom_range(0, 1)), DATA_W'($urandom));
            end
         end
         applyStimulus(0, 0, 1, 0, 0, '0);
         idle(2);
         checkDrained("rand_pending");
      end

      idle(3);
      checkDrained("final_pending");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
